// File: rtl/cmp_pipe.sv
// Two-stage valid/ready comparator: stage 1 holds the operands, stage 2 holds the result.
// A saturating counter tallies delivered true results.
module cmp_pipe #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_op,
  input  logic                   in_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_z,
  output logic                   out_err,
  input  logic                   clear_count,
  output logic [COUNT_WIDTH-1:0] true_count
);

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_LE = 3'b011;
  localparam logic [2:0] OP_GT = 3'b100;
  localparam logic [2:0] OP_GE = 3'b101;

  logic                   run_q;
  logic                   s1_vld_q, s1_vld_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [2:0]             op_q, op_d;
  logic                   sgn_q, sgn_d;
  logic                   z_q, z_d, err_q, err_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                   s1_adv, s2_adv, in_fire, deliver;
  logic [WIDTH-1:0]       a_x, b_x;
  logic                   lt, eq, cmp_z, cmp_err;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = s2_adv || !s1_vld_q;
  // run_q keeps in_ready low during reset and raises it at the first edge after release
  assign in_ready = run_q && s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign deliver  = s2_vld_q && out_ready;

  // Flipping the sign bit maps two's-complement order onto unsigned order
  assign a_x = {a_q[WIDTH-1] ^ sgn_q, a_q[WIDTH-2:0]};
  assign b_x = {b_q[WIDTH-1] ^ sgn_q, b_q[WIDTH-2:0]};
  assign lt  = a_x < b_x;
  assign eq  = a_q == b_q;

  always_comb begin
    cmp_z   = 1'b0;
    cmp_err = 1'b0;
    case (op_q)
      OP_EQ:   cmp_z = eq;
      OP_NE:   cmp_z = !eq;
      OP_LT:   cmp_z = lt;
      OP_LE:   cmp_z = lt || eq;
      OP_GT:   cmp_z = !lt && !eq;
      OP_GE:   cmp_z = !lt;
      default: cmp_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    s2_vld_d = s2_vld_q;
    z_d      = z_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (s1_adv) s1_vld_d = in_fire;
    if (in_fire) begin
      a_d   = in_a;
      b_d   = in_b;
      op_d  = in_op;
      sgn_d = in_signed;
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        z_d   = cmp_z;
        err_d = cmp_err;
      end
    end
    if (clear_count)
      cnt_d = '0;
    else if (deliver && z_q && cnt_q != '1)
      cnt_d = cnt_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sgn_q    <= 1'b0;
      z_q      <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      run_q    <= 1'b1;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      z_q      <= z_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_z      = z_q;
  assign out_err    = err_q;
  assign true_count = cnt_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed and randomized checks of cmp_pipe against an independent compare model.
module tb_cmp_pipe;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0, clear_count = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [2:0]    in_op = '0;
  logic          in_ready, out_valid, out_z, out_err;
  logic [CW-1:0] true_count;

  cmp_pipe #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_err(out_err),
    .clear_count(clear_count), .true_count(true_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, n_acc = 0, n_del = 0;
  int          first_acc = -1, first_del = -1, last_del = -1;
  int unsigned mcnt = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  got_q[$];
  logic        phold = 1'b0;
  logic [1:0]  prev_res = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {err, z}
  function automatic logic [1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op, logic s);
    logic lt_m, eq_m;
    eq_m = (a == b);
    lt_m = s ? ($signed(a) < $signed(b)) : (a < b);
    case (op)
      3'd0:    return {1'b0, eq_m};
      3'd1:    return {1'b0, !eq_m};
      3'd2:    return {1'b0, lt_m};
      3'd3:    return {1'b0, lt_m | eq_m};
      3'd4:    return {1'b0, !lt_m & !eq_m};
      3'd5:    return {1'b0, !lt_m};
      default: return 2'b10;
    endcase
  endfunction

  // Observe mid-cycle, record handshakes that the next rising edge will complete.
  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    if (phold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", {out_err, out_z}, prev_res);
    end
    phold    = out_valid && !out_ready;
    prev_res = {out_err, out_z};
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_a, in_b, in_op, in_signed));
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (out_valid && out_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b11;
      chk("result", {out_err, out_z}, e);
      got_q.push_back({out_err, out_z});
      n_del++;
      if (first_del < 0) first_del = cyc;
      last_del = cyc;
    end
    if (clear_count) mcnt = 0;
    else if (out_valid && out_ready && out_z && mcnt != 15) mcnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input logic s);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_signed = s;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lim;
    logic [5:0] flow_z;
    logic [2:0] bp_ops [5];

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_count", true_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // continuous flow, a=5 b=3 over eq..ge
    out_ready = 1'b1; first_acc = -1; first_del = -1; got_q.delete(); base = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive(32'd5, 32'd3, 3'(i), 1'b0);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    flow_z = 6'b110010;
    chk("flow_accepts", n_acc - base, 6);
    chk("flow_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk($sformatf("flow_z%0d", i), got_q[i], {1'b0, flow_z[i]});
    chk("flow_latency", first_del - first_acc, 2);
    chk("flow_no_bubbles", last_del - first_del, 5);
    chk("flow_true_count", true_count, 3);

    // signed vs unsigned
    got_q.delete();
    drive(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b1); step();
    drive(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0); step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("sgn_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("signed_lt", got_q[0], 2'b01);
      chk("unsigned_lt", got_q[1], 2'b00);
    end

    // back-pressure: only two get in, results held, then drain in order
    got_q.delete(); base = n_acc; out_ready = 1'b0;
    bp_ops = '{3'd2, 3'd0, 3'd5, 3'd4, 3'd1};
    for (int i = 0; i < 5; i++) begin
      drive(32'd7, 32'd9, bp_ops[i], 1'b0);
      step();
    end
    chk("bp_accepts", n_acc - base, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_held_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("bp_drained", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_first", got_q[0], 2'b01);
      chk("bp_second", got_q[1], 2'b00);
    end

    // counter saturation and clear priority
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("cnt_cleared", true_count, 0);
    base = n_del; lim = 0;
    drive(32'd1, 32'd1, 3'd0, 1'b0);
    while (n_del - base < 20 && lim < 40) begin step(); lim++; end
    chk("cnt_20_delivered", n_del - base, 20);
    chk("cnt_saturated", true_count, 15);
    chk("cnt_model", true_count, mcnt);
    chk("clr_coincide_true", out_valid & out_ready & out_z, 1);
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("clr_priority", true_count, 0);
    in_valid = 1'b0;
    repeat (3) step();
    chk("cnt_after_drain", true_count, 2);

    // reserved ops
    got_q.delete();
    drive(32'd4, 32'd4, 3'b110, 1'b0); step();
    drive(32'd4, 32'd4, 3'b111, 1'b1); step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("rsv_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("rsv_110", got_q[0], 2'b10);
      chk("rsv_111", got_q[1], 2'b10);
    end

    // reset with two transactions in flight
    out_ready = 1'b0; base = n_acc;
    drive(32'd1, 32'd2, 3'd2, 1'b0); step(); step();
    in_valid = 1'b0;
    chk("inflight_accepts", n_acc - base, 2);
    chk("inflight_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_count", true_count, 0);
    exp_q.delete(); phold = 1'b0; mcnt = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rerst_in_ready", in_ready, 1);
    out_ready = 1'b1; base = n_del;
    repeat (5) step();
    chk("no_stale", n_del - base, 0);

    // random traffic against the model
    base = n_acc; lim = 0;
    while (n_acc - base < 10000 && lim < 60000) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_a        = $urandom;
      in_b        = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
      if ($urandom_range(0, 7) == 0) in_a[W-1] = ~in_b[W-1];
      in_op       = 3'($urandom_range(0, 7));
      in_signed   = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_count = ($urandom_range(0, 63) == 0);
      step();
      lim++;
    end
    chk("rand_accepts", n_acc - base, 10000);
    in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
    lim = 0;
    while (exp_q.size() > 0 && lim < 10) begin step(); lim++; end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_count", true_count, mcnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16: width of the true-result counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: input transaction offered.
REQ-006 SHALL have port in_ready, output, 1 bit: input transaction accepted when in_valid and in_ready are both high.
REQ-007 SHALL have ports in_a and in_b, input, WIDTH bits each: operands.
REQ-008 SHALL have port in_op, input, 3 bits: 000 eq, 001 ne, 010 lt, 011 le, 100 gt, 101 ge, 110/111 reserved.
REQ-009 SHALL have port in_signed, input, 1 bit: 1 = two's-complement compare, 0 = unsigned compare.
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_z, output, 1 bit: comparison result.
REQ-013 SHALL have port out_err, output, 1 bit: result came from a reserved op.
REQ-014 SHALL have port clear_count, input, 1 bit: synchronous clear of true_count.
REQ-015 SHALL have port true_count, output, COUNT_WIDTH bits: number of delivered results with out_z=1.

Function
REQ-016 SHALL implement a 2-stage pipeline: stage 1 registers in_a, in_b, in_op and in_signed; stage 2 registers out_z and out_err.
REQ-017 SHALL present each accepted input's result with out_valid high exactly 2 cycles after acceptance when out_ready is held high.
REQ-018 SHALL advance stage 2 when its valid bit is low or out_ready is high.
REQ-019 SHALL advance stage 1 when stage 2 advances or stage 1 is empty.
REQ-020 SHALL drive in_ready combinationally as: stage 1 empty OR stage 1 advancing; this gives one transaction per cycle under continuous flow.
REQ-021 SHALL hold out_z, out_err and out_valid stable while out_valid=1 and out_ready=0; no result is dropped or duplicated.
REQ-022 SHALL, with out_ready=0, accept at most 2 transactions before in_ready goes low.
REQ-023 SHALL, for signed compares, treat bit WIDTH-1 as the sign bit; all other bits and unsigned compares are magnitude.
REQ-024 SHALL, for reserved ops, drive out_z=0 and out_err=1; for all other ops out_err=0.
REQ-025 SHALL increment true_count by 1 on each cycle with out_valid, out_ready and out_z all high.
REQ-026 SHALL saturate true_count at all-ones; no wrap-around to 0.
REQ-027 SHALL give clear_count priority over an increment in the same cycle: the result is true_count=0.
REQ-028 SHALL keep the pipeline free of combinational paths from out_ready to out_valid or out_z.

Reset
REQ-029 SHALL, while rst=1, force in_ready=0, out_valid=0, out_z=0, out_err=0, true_count=0, and both stage valid bits to 0.
REQ-030 SHALL discard any in-flight transactions when rst asserts mid-operation; none of them appear after reset.
REQ-031 SHALL drive in_ready=1 on the first rising clk edge after rst deasserts.

Verification
REQ-032 Continuous-flow scenario: WIDTH=32, out_ready=1, one op per cycle over eq/ne/lt/le/gt/ge with a=5, b=3 -> out_z sequence 0,1,0,0,1,1, first result 2 cycles after first acceptance, no bubbles.
REQ-033 Signed/unsigned scenario: a=32'hFFFFFFFF, b=1, op=lt -> out_z=1 with in_signed=1 and out_z=0 with in_signed=0.
REQ-034 Back-pressure scenario: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 transactions accepted, in_ready=0 afterwards, outputs held stable; then out_ready=1 -> results drain in order with no loss.
REQ-035 Counter scenario: COUNT_WIDTH=4, 20 delivered true results -> true_count saturates at 15; clear_count asserted together with a true delivery -> true_count=0.
REQ-036 Reserved-op and reset scenario: op=110 -> out_z=0, out_err=1; rst asserted with 2 transactions in flight -> out_valid=0 immediately and no stale result after release.
REQ-037 Random scenario: 10,000 random operands, ops and in_signed values with random out_ready -> every result matches the reference model, in order, with true_count equal to the model's count.
